// File: rtl/deriv_rom_arbiter.sv
// deriv_rom_arbiter: round-robin sharing of one registered-output derivative ROM
// among NUM_REQ requesters, with a one-deep response stage and a lookup counter.
module deriv_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic                          rsp_valid,
    output logic [IW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready,
    input  logic                          cnt_clr,
    output logic [15:0]                   lookup_cnt,
    output logic                          busy
);
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  found;
    logic                  accept;
    int                    idx;
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        // scan farthest-first so the nearest valid index at/after ptr wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                gnt   = IW'(idx);
            end
        end
    end
    assign accept    = rst_n && (!rsp_valid || rsp_ready) && found;
    assign req_ready = accept ? (NUM_REQ'(1) << gnt) : '0;
    assign rom_addr  = accept ? req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH] : addr_hold;
    // the ROM output register is the response register; only gate it here
    assign rsp_data  = rsp_valid ? rom_dout : '0;
    assign busy      = |req_valid || rsp_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            addr_hold  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            lookup_cnt <= '0;
        end else begin
            if (accept) begin
                ptr       <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                addr_hold <= rom_addr;
                rsp_valid <= 1'b1;
                rsp_id    <= gnt;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (cnt_clr) lookup_cnt <= '0;
            else if (rsp_valid && rsp_ready && lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_deriv_rom_arbiter.sv
// tb_deriv_rom_arbiter: directed and randomized checks of deriv_rom_arbiter
// against a transaction-level model driving a registered ROM.
module tb_deriv_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_dout = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] lookup_cnt;
    logic        busy;
    logic [7:0]  mem [256];
    int checks = 0;
    int failures = 0;

    deriv_rom_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .cnt_clr(cnt_clr), .lookup_cnt(lookup_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_dout <= mem[rom_addr];

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        rsp_ready = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_addr = 32'h80_67_47_05;
        rsp_ready = 1'b1;
        #1;
        checks += 6;
        if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        if (rom_addr !== 8'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        if (rsp_data !== 8'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        if (lookup_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", lookup_cnt); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_addr[7:0] = 8'd23;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        if (rom_addr !== 8'd23) begin failures++; $display("FAIL single_rom_addr got=%0d exp=23", rom_addr); end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checks += 4;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        if (rsp_data !== 8'hFE) begin failures++; $display("FAIL single_rsp_data got=%h exp=fe", rsp_data); end
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_drop got=%b exp=0000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid); end
        if (rsp_data !== 8'h00) begin failures++; $display("FAIL single_data_zero got=%h exp=00", rsp_data); end
        if (lookup_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", lookup_cnt); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [4];
        exp_data = '{8'hFF, 8'hFC, 8'hFA, 8'h00};
        do_reset();
        req_valid = 4'hF;
        req_addr = {8'd128, 8'd103, 8'd71, 8'd5};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << i)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, 4'(1 << i)); end
            if (i > 0) begin
                checks += 2;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(i - 1)) begin failures++; $display("FAIL rr_rsp_id%0d got=%b/%0d exp=1/%0d", i, rsp_valid, rsp_id, i - 1); end
                if (rsp_data !== exp_data[i-1]) begin failures++; $display("FAIL rr_rsp_data%0d got=%h exp=%h", i, rsp_data, exp_data[i-1]); end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        @(negedge clk);
        checks += 2;
        if (rsp_id !== 2'd3) begin failures++; $display("FAIL rr_rsp_id3 got=%0d exp=3", rsp_id); end
        if (rsp_data !== 8'h00) begin failures++; $display("FAIL rr_rsp_data3 got=%h exp=00", rsp_data); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (lookup_cnt !== 16'd4) begin failures++; $display("FAIL rr_cnt got=%0d exp=4", lookup_cnt); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_rsp_clear got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0010;
        req_addr = {8'd128, 8'd103, 8'd71, 8'd5};
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 4'b1101;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 4;
            if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", i, req_ready); end
            if (rom_addr !== 8'd71) begin failures++; $display("FAIL bp_rom_addr%0d got=%0d exp=71", i, rom_addr); end
            if (rsp_data !== 8'hFC) begin failures++; $display("FAIL bp_data%0d got=%h exp=fc", i, rsp_data); end
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin failures++; $display("FAIL bp_hold%0d got=%b/%0d exp=1/1", i, rsp_valid, rsp_id); end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_grant got=%b exp=0100", req_ready); end
        if (rom_addr !== 8'd103) begin failures++; $display("FAIL bp_release_addr got=%0d exp=103", rom_addr); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_next_id got=%b/%0d exp=1/2", rsp_valid, rsp_id); end
        if (rsp_data !== 8'hFA) begin failures++; $display("FAIL bp_next_data got=%h exp=fa", rsp_data); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 4'b0100;
        req_addr = {8'd128, 8'd103, 8'd71, 8'd5};
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 4'b1010;
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
        if (rsp_id !== 2'd0) begin failures++; $display("FAIL mid_rsp_id got=%0d exp=0", rsp_id); end
        if (rsp_data !== 8'h0) begin failures++; $display("FAIL mid_rsp_data got=%h exp=0", rsp_data); end
        if (req_ready !== 4'h0) begin failures++; $display("FAIL mid_req_ready got=%b exp=0000", req_ready); end
        if (rom_addr !== 8'h0) begin failures++; $display("FAIL mid_rom_addr got=%0d exp=0", rom_addr); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checks += 2;
        if (rsp_id !== 2'd1) begin failures++; $display("FAIL mid_rsp_id_after got=%0d exp=1", rsp_id); end
        if (rsp_data !== 8'hFC) begin failures++; $display("FAIL mid_rsp_data_after got=%h exp=fc", rsp_data); end
    endtask

    task automatic test_random();
        int m_ptr, m_id, m_cnt, g;
        bit m_rv, hs, issue;
        logic [7:0] m_addr, m_hold, a;
        logic [3:0] exp_ready;
        logic [7:0] exp_rom;
        do_reset();
        m_ptr = 0; m_id = 0; m_cnt = 0; m_rv = 0; m_addr = 0; m_hold = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_addr = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            issue = !m_rv || rsp_ready;
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            exp_ready = (issue && g >= 0) ? 4'(1 << g) : 4'h0;
            a = (g >= 0) ? req_addr[g*8 +: 8] : 8'h0;
            exp_rom = (issue && g >= 0) ? a : m_hold;
            @(negedge clk);
            checks += 7;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            if (rom_addr !== exp_rom) begin failures++; $display("FAIL rnd_rom_addr c=%0d got=%h exp=%h", c, rom_addr, exp_rom); end
            if (rsp_valid !== m_rv) begin failures++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, m_rv); end
            if (m_rv && rsp_id !== 2'(m_id)) begin failures++; $display("FAIL rnd_rsp_id c=%0d got=%0d exp=%0d", c, rsp_id, m_id); end
            if (rsp_data !== (m_rv ? mem[m_addr] : 8'h0)) begin failures++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, m_rv ? mem[m_addr] : 8'h0); end
            if (busy !== (|req_valid || m_rv)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
            if (lookup_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, lookup_cnt, m_cnt); end
            @(posedge clk);
            hs = m_rv && rsp_ready;
            m_cnt = cnt_clr ? 0 : (hs && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (issue && g >= 0) begin
                m_rv = 1; m_id = g; m_addr = a; m_hold = a; m_ptr = (g + 1) % 4;
            end else if (hs) m_rv = 0;
            #1;
        end
        cnt_clr = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_counter();
        int n;
        do_reset();
        req_valid = 4'b0001;
        req_addr = 32'd5;
        rsp_ready = 1'b1;
        n = 0;
        while (lookup_cnt !== 16'hFFFF && n < 70000) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (lookup_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_reach_max got=%h exp=ffff after %0d cycles", lookup_cnt, n); end
        checks++;
        if (n != 65536) begin failures++; $display("FAIL cnt_max_cycles got=%0d exp=65536", n); end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL cnt_streaming got=%b exp=1", rsp_valid); end
        if (lookup_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_saturate got=%h exp=ffff", lookup_cnt); end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        checks++;
        if (lookup_cnt !== 16'h0) begin failures++; $display("FAIL cnt_clr_priority got=%h exp=0", lookup_cnt); end
        @(posedge clk);
        #1;
        checks++;
        if (lookup_cnt !== 16'h1) begin failures++; $display("FAIL cnt_after_clr got=%h exp=1", lookup_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[23] = 8'hFE;
        mem[5] = 8'hFF;
        mem[71] = 8'hFC;
        mem[103] = 8'hFA;
        mem[128] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
